// File: rtl/int_pe_pkg.sv
// rtl/int_pe_pkg.sv - shared types and overflow-aware adder for the integer MAC PE.
// Saturating adds are selected with INT_MAC_PE_SAT_EN; wrapping adds otherwise.
package int_pe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } pe_state_e;

    // Arithmetic helpers work at this fixed width; callers use the low w bits.
    localparam int unsigned      MAX_W    = 64;
    localparam logic [MAX_W-1:0] ALL_ONES = '1;
    localparam logic [MAX_W-1:0] ONE      = MAX_W'(1);

    function automatic logic [MAX_W-1:0] umax(input int unsigned w);
        return (w >= MAX_W) ? ALL_ONES : ((ONE << w) - ONE);
    endfunction

    function automatic logic [MAX_W-1:0] smax(input int unsigned w);
        return umax(w) >> 1;
    endfunction

    function automatic logic [MAX_W-1:0] smin(input int unsigned w);
        return ONE << (w - 1);
    endfunction

    // Returns {ovf, sum}; operands are w-bit values in the low bits of a and b.
    function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input logic             signed_mode,
                                               input int unsigned      w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] msb;
        logic [MAX_W-1:0] sum;
        logic [MAX_W:0]   full;
        logic             sa;
        logic             sb;
        logic             ss;
        logic             ovf;
        mask = umax(w);
        msb  = smin(w);
        full = {1'b0, a & mask} + {1'b0, b & mask};
        sum  = full[MAX_W-1:0] & mask;
        sa   = |(a & msb);
        sb   = |(b & msb);
        ss   = |(sum & msb);
        if (signed_mode) begin
            ovf = (sa == sb) && (ss != sa);
        end else if (w >= MAX_W) begin
            ovf = full[MAX_W];
        end else begin
            ovf = |(full[MAX_W-1:0] & ~mask);
        end
`ifdef INT_MAC_PE_SAT_EN
        if (ovf) begin
            if (signed_mode) begin
                sum = sa ? msb : smax(w);
            end else begin
                sum = mask;
            end
        end
`endif
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/int_pe_mul_reg.sv
// rtl/int_pe_mul_reg.sv - product stage: registered signed/unsigned multiplier with sideband.
module int_pe_mul_reg #(
    parameter int W_A = 8,
    parameter int W_B = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en_i,
    input  logic                 valid_i,
    input  logic                 first_i,
    input  logic                 last_i,
    input  logic                 signed_i,
    input  logic [W_A-1:0]       a_i,
    input  logic [W_B-1:0]       b_i,
    output logic [W_A+W_B-1:0]   p_o,
    output logic                 valid_o,
    output logic                 first_o,
    output logic                 last_o,
    output logic                 signed_o
);

    localparam int W_P = W_A + W_B;

    logic [W_P-1:0] a_s;
    logic [W_P-1:0] a_u;
    logic [W_P-1:0] b_s;
    logic [W_P-1:0] b_u;
    logic [W_P-1:0] p_d;
    logic [W_P-1:0] p_q;
    logic           valid_q;
    logic           first_q;
    logic           last_q;
    logic           signed_q;

    // Both operands extended to the full product width, so the truncated product is exact.
    always_comb begin
        a_s = W_P'($signed(a_i));
        a_u = W_P'(a_i);
        b_s = W_P'($signed(b_i));
        b_u = W_P'(b_i);
        p_d = signed_i ? (a_s * b_s) : (a_u * b_u);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_q      <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            signed_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                p_q      <= p_d;
                first_q  <= first_i;
                last_q   <= last_i;
                signed_q <= signed_i;
            end
        end
    end

    assign p_o      = p_q;
    assign valid_o  = valid_q;
    assign first_o  = first_q;
    assign last_o   = last_q;
    assign signed_o = signed_q;

endmodule

// File: rtl/int_mac_pe_pipe.sv
// rtl/int_mac_pe_pipe.sv - pipelined handshaked integer dot-product PE (bias + sum of a*b).
// Define INT_MAC_PE_SAT_EN to clamp on overflow instead of wrapping.
module int_mac_pe_pipe
    import int_pe_pkg::*;
#(
    parameter int W_A   = 8,
    parameter int W_B   = 16,
    parameter int W_ACC = 32,
    parameter int W_LEN = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_signed,
    input  logic [W_LEN-1:0] cfg_len,
    input  logic [W_ACC-1:0] cfg_bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_A-1:0]   in_a,
    input  logic [W_B-1:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_ACC-1:0] out_x,
    output logic             out_ovf
);

    localparam int W_P = W_A + W_B;

    if (W_ACC < W_P) begin : g_acc_width_chk
        $error("int_mac_pe_pipe: W_ACC must be >= W_A+W_B");
    end
    if (W_ACC > MAX_W) begin : g_acc_max_chk
        $error("int_mac_pe_pipe: W_ACC exceeds adder width");
    end

    pe_state_e        state_q, state_d;
    logic [W_LEN-1:0] cnt_q, cnt_d;
    logic [W_LEN-1:0] len_q, len_d;
    logic [W_LEN-1:0] len_eff;
    logic             signed_q, signed_d;
    logic [W_ACC-1:0] bias_q, bias_d;
    logic             accept;
    logic             beat_first;
    logic             beat_last;
    logic             beat_signed;

    logic [W_P-1:0]   p;
    logic             p_valid;
    logic             p_first;
    logic             p_last;
    logic             p_signed;
    logic             stall;

    logic [W_ACC-1:0] acc_q, acc_d;
    logic             sticky_q, sticky_d;
    logic             out_valid_q, out_valid_d;
    logic [W_ACC-1:0] out_x_q, out_x_d;
    logic             out_ovf_q, out_ovf_d;
    logic [W_ACC-1:0] p_ext_s;
    logic [W_ACC-1:0] p_ext_u;
    logic [W_ACC-1:0] p_ext;
    logic [W_ACC-1:0] base;
    logic [MAX_W:0]   add_r;
    logic [W_ACC-1:0] add_sum;
    logic             add_ovf;

    assign in_ready = rstn & ~(out_valid_q & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign len_eff  = (cfg_len == '0) ? W_LEN'(1) : cfg_len;

    // Beat sequencing; configuration is captured only by the first beat of a product.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        signed_d    = signed_q;
        bias_d      = bias_q;
        beat_first  = (state_q == IDLE);
        beat_signed = beat_first ? cfg_signed : signed_q;
        beat_last   = beat_first ? (len_eff == W_LEN'(1)) : ((cnt_q + W_LEN'(1)) == len_q);
        if (accept) begin
            if (beat_first) begin
                len_d    = len_eff;
                signed_d = cfg_signed;
                bias_d   = cfg_bias;
            end
            if (beat_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = ACC;
                cnt_d   = cnt_q + W_LEN'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            signed_q <= 1'b0;
            bias_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            signed_q <= signed_d;
            bias_q   <= bias_d;
        end
    end

    // A finished sum cannot land while the previous result is still unconsumed, so the
    // product stage holds; no new beat can arrive then because in_ready is already low.
    assign stall = p_valid & p_last & out_valid_q & ~out_ready;

    int_pe_mul_reg #(
        .W_A (W_A),
        .W_B (W_B)
    ) u_mul (
        .clk      (clk),
        .rstn     (rstn),
        .en_i     (~stall),
        .valid_i  (accept),
        .first_i  (beat_first),
        .last_i   (beat_last),
        .signed_i (beat_signed),
        .a_i      (in_a),
        .b_i      (in_b),
        .p_o      (p),
        .valid_o  (p_valid),
        .first_o  (p_first),
        .last_o   (p_last),
        .signed_o (p_signed)
    );

    always_comb begin
        p_ext_s = W_ACC'($signed(p));
        p_ext_u = W_ACC'(p);
        p_ext   = p_signed ? p_ext_s : p_ext_u;
        base    = p_first ? bias_q : acc_q;
        add_r   = sat_add(MAX_W'(base), MAX_W'(p_ext), p_signed, W_ACC);
        add_sum = add_r[W_ACC-1:0];
        add_ovf = add_r[MAX_W];
    end

    if (W_ACC < MAX_W) begin : g_unused_hi
        logic unused_sum_hi;
        assign unused_sum_hi = |add_r[MAX_W-1:W_ACC];
    end

    always_comb begin
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_ovf_d   = out_ovf_q;
        if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end
        if (p_valid & ~stall) begin
            if (p_last) begin
                out_x_d     = add_sum;
                out_ovf_d   = sticky_q | add_ovf;
                out_valid_d = 1'b1;
                acc_d       = '0;
                sticky_d    = 1'b0;
            end else begin
                acc_d    = add_sum;
                sticky_d = sticky_q | add_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_ovf   = out_ovf_q;

endmodule
